// File: rtl/noise_cdf_loader.sv
// rtl/noise_cdf_loader.sv - CDF table stream loader for the 128-level noise generator
//
// Purpose: accepts DEPTH cumulative-probability entries as a valid/ready
// stream, writes them to the generator table port (location/mem_data/load_mem)
// one cycle after each accept, appends TAIL_BEATS rewrites of the last entry
// to flush the write port, then reports done and enables the generator unless
// a non-monotonic entry was seen.
//
// Ports:
//   clk_i         system clock
//   rst_i         synchronous reset, active-high
//   start_i       1-cycle pulse, begins a table load (honoured in IDLE/DONE)
//   cdf_data_i    CDF entry, ascending location order
//   cdf_valid_i   cdf_data_i valid
//   cdf_ready_o   beat accepted this cycle when cdf_valid_i is high
//   location_o    table write address
//   mem_data_o    table write data
//   load_mem_o    table write strobe
//   busy_o        load in progress (LOAD or TAIL)
//   done_o        table fully written
//   gen_en_o      generator enable (done and no error)
//   err_o         sticky non-monotonic entry flag
//   err_index_o   location of the first non-monotonic entry
module noise_cdf_loader #(
   parameter int DEPTH      = 128,
   parameter int TAIL_BEATS = 2,
   parameter int DW         = 64
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic [DW-1:0] cdf_data_i,
   input  logic          cdf_valid_i,
   output logic          cdf_ready_o,
   output logic [7:0]    location_o,
   output logic [DW-1:0] mem_data_o,
   output logic          load_mem_o,
   output logic          busy_o,
   output logic          done_o,
   output logic          gen_en_o,
   output logic          err_o,
   output logic [7:0]    err_index_o
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_TAIL, S_DONE} state_e;

   localparam int          TW       = (TAIL_BEATS < 1) ? 1 : $clog2(TAIL_BEATS + 1);
   localparam logic [7:0]  LAST_IDX = 8'(DEPTH - 1);
   localparam logic [TW-1:0] TAIL_N = TW'(TAIL_BEATS);

   state_e          state_q, state_d;
   logic [7:0]      idx_q, idx_d;
   logic [DW-1:0]   prev_q, prev_d;
   logic [TW-1:0]   tail_q, tail_d;
   logic [7:0]      loc_q, loc_d;
   logic [DW-1:0]   data_q, data_d;
   logic            lm_q, lm_d;
   logic            err_q, err_d;
   logic [7:0]      eidx_q, eidx_d;
   logic            accept;

   // Ready depends only on registered state, never on cdf_valid_i.
   assign accept = cdf_valid_i && (state_q == S_LOAD);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      prev_d  = prev_q;
      tail_d  = tail_q;
      loc_d   = loc_q;
      data_d  = data_q;
      lm_d    = 1'b0;
      err_d   = err_q;
      eidx_d  = eidx_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d = S_LOAD;
               idx_d   = '0;
               prev_d  = '0;
               tail_d  = '0;
               err_d   = 1'b0;
               eidx_d  = '0;
            end
         end
         S_LOAD: begin
            if (accept) begin
               lm_d   = 1'b1;
               loc_d  = idx_q;
               data_d = cdf_data_i;
               prev_d = cdf_data_i;
               // Entry 0 has no predecessor; only the first violation is recorded.
               if ((idx_q != 8'd0) && (cdf_data_i < prev_q) && !err_q) begin
                  err_d  = 1'b1;
                  eidx_d = idx_q;
               end
               // idx stops at the last entry so DEPTH=256 cannot wrap.
               if (idx_q == LAST_IDX) begin
                  state_d = S_TAIL;
                  tail_d  = '0;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
         end
         S_TAIL: begin
            // Idempotent rewrites of the last entry flush the pipelined address.
            if (tail_q != TAIL_N) begin
               lm_d   = 1'b1;
               loc_d  = LAST_IDX;
               data_d = prev_q;
               tail_d = tail_q + TW'(1);
            end else begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         prev_q  <= '0;
         tail_q  <= '0;
         loc_q   <= '0;
         data_q  <= '0;
         lm_q    <= 1'b0;
         err_q   <= 1'b0;
         eidx_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         prev_q  <= prev_d;
         tail_q  <= tail_d;
         loc_q   <= loc_d;
         data_q  <= data_d;
         lm_q    <= lm_d;
         err_q   <= err_d;
         eidx_q  <= eidx_d;
      end
   end

   assign cdf_ready_o = (state_q == S_LOAD);
   assign busy_o      = (state_q == S_LOAD) || (state_q == S_TAIL);
   assign done_o      = (state_q == S_DONE);
   assign gen_en_o    = (state_q == S_DONE) && !err_q;
   assign err_o       = err_q;
   assign err_index_o = eidx_q;
   assign location_o  = loc_q;
   assign mem_data_o  = data_q;
   assign load_mem_o  = lm_q;

endmodule

// File: tb/tb_noise_cdf_loader.sv
// tb/tb_noise_cdf_loader.sv - self-checking bench for noise_cdf_loader
module tb_noise_cdf_loader;

   localparam int DEPTH = 128;
   localparam int TAIL  = 2;
   localparam int DW    = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] cdf_data = '0;
   logic          cdf_valid = 1'b0;
   logic          cdf_ready;
   logic [7:0]    location;
   logic [DW-1:0] mem_data;
   logic          load_mem;
   logic          busy;
   logic          done;
   logic          gen_en;
   logic          err;
   logic [7:0]    err_index;

   noise_cdf_loader #(.DEPTH(DEPTH), .TAIL_BEATS(TAIL), .DW(DW)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start),
      .cdf_data_i(cdf_data), .cdf_valid_i(cdf_valid), .cdf_ready_o(cdf_ready),
      .location_o(location), .mem_data_o(mem_data), .load_mem_o(load_mem),
      .busy_o(busy), .done_o(done), .gen_en_o(gen_en),
      .err_o(err), .err_index_o(err_index)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: table-load progress expressed as counters.
   // phase: 0 idle, 1 taking entries, 2 flushing, 3 committed
   int            m_phase = 0;
   int            m_acc = 0;
   int            m_flush_left = 0;
   logic          m_lm = 0;
   int            m_loc = 0;
   logic [DW-1:0] m_data = '0;
   logic [DW-1:0] m_prev = '0;
   logic          m_err = 0;
   int            m_eidx = 0;

   logic [DW-1:0] vals [DEPTH];
   int            strobes = 0;
   bit            chk_en = 0;
   bit            want_first = 0;
   int            first_loc = -1;
   int            cyc = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      if (rst) begin
         m_phase = 0; m_acc = 0; m_flush_left = 0; m_lm = 0; m_loc = 0;
         m_data = '0; m_prev = '0; m_err = 0; m_eidx = 0;
      end else begin
         m_lm = 0;
         if (m_phase == 0 || m_phase == 3) begin
            if (start) begin
               m_phase = 1; m_acc = 0; m_prev = '0; m_err = 0; m_eidx = 0;
            end
         end else if (m_phase == 1) begin
            if (cdf_valid) begin
               m_lm = 1; m_loc = m_acc; m_data = cdf_data;
               if (m_acc > 0 && cdf_data < m_prev && !m_err) begin
                  m_err = 1; m_eidx = m_acc;
               end
               m_prev = cdf_data;
               m_acc++;
               if (m_acc == DEPTH) begin
                  m_phase = 2; m_flush_left = TAIL;
               end
            end
         end else begin
            if (m_flush_left > 0) begin
               m_lm = 1; m_loc = DEPTH - 1; m_flush_left--;
            end else begin
               m_phase = 3;
            end
         end
      end
   endtask

   task automatic compare();
      chk("cdf_ready", cdf_ready, (m_phase == 1));
      chk("busy", busy, (m_phase == 1 || m_phase == 2));
      chk("done", done, (m_phase == 3));
      chk("gen_en", gen_en, (m_phase == 3 && !m_err));
      chk("err", err, m_err);
      chk("err_index", err_index, m_eidx);
      chk("load_mem", load_mem, m_lm);
      if (m_lm) begin
         chk("location", location, m_loc);
         chk("mem_data", mem_data, m_data);
      end
      if (load_mem === 1'b1) begin
         strobes++;
         if (want_first) begin
            first_loc = location;
            want_first = 0;
         end
      end
   endtask

   // One clock: check outputs at the falling edge, advance the model at the
   // rising edge, then return just after it so inputs change away from the edge.
   task automatic tick();
      @(negedge clk);
      if (chk_en) compare();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
   endtask

   task automatic pulse_start();
      start = 1;
      tick();
      start = 0;
   endtask

   // mode 0 back-to-back, 1 alternating 1/0, 2 random gaps
   task automatic stream(input int mode, input int stop_at, input int start_at);
      int guard = 0;
      bit started = 0;
      while (m_phase == 1 && m_acc < stop_at && guard < 2000) begin
         case (mode)
            0: cdf_valid = 1;
            1: cdf_valid = (guard % 2 == 0);
            default: cdf_valid = ($urandom_range(0, 2) != 0);
         endcase
         cdf_data = vals[m_acc];
         start = (m_acc == start_at && !started);
         if (start) started = 1;
         tick();
         guard++;
      end
      cdf_valid = 0;
      start = 0;
      if (guard >= 2000) chk("stream_timeout", 1, 0);
   endtask

   task automatic wait_done();
      int guard = 0;
      while (m_phase != 3 && guard < 50) begin
         tick();
         guard++;
      end
      if (guard >= 50) chk("done_timeout", 1, 0);
   endtask

   task automatic fill_ramp();
      for (int k = 0; k < DEPTH; k++) vals[k] = DW'(k) << 56;
   endtask

   task automatic fill_random();
      vals[0] = 64'd1000 + DW'($urandom_range(0, 100));
      for (int k = 1; k < DEPTH; k++) vals[k] = vals[k-1] + DW'($urandom_range(0, 1000));
   endtask

   initial begin
      int base;
      tick(); tick();
      chk_en = 1;
      rst = 0;
      // reset state pinned by literals
      chk("rst_load_mem", load_mem, 0);
      chk("rst_ready", cdf_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_location", location, 0);

      // T6a: valid in IDLE is ignored
      fill_ramp();
      base = strobes;
      cdf_valid = 1; cdf_data = vals[0];
      for (int i = 0; i < 10; i++) tick();
      cdf_valid = 0;
      chk("T6_idle_strobes", strobes - base, 0);

      // T1: back-to-back ramp
      base = strobes;
      pulse_start();
      stream(0, DEPTH, -1);
      wait_done();
      tick();
      chk("T1_strobes", strobes - base, 130);
      chk("T1_done", done, 1);
      chk("T1_gen_en", gen_en, 1);
      chk("T1_err", err, 0);

      // T6b: valid in DONE is ignored
      base = strobes;
      cdf_valid = 1;
      for (int i = 0; i < 10; i++) tick();
      cdf_valid = 0;
      chk("T6_done_strobes", strobes - base, 0);

      // T2: alternating valid, restart from DONE
      fill_random();
      base = strobes;
      pulse_start();
      chk("T6_done_drops", done, 0);
      stream(1, DEPTH, -1);
      wait_done();
      tick();
      chk("T2_strobes", strobes - base, 130);

      // T3: two decreasing entries, only the first reported
      fill_random();
      vals[40] = vals[39] - 1;
      vals[90] = vals[89] - 5;
      pulse_start();
      stream(2, DEPTH, -1);
      wait_done();
      tick();
      chk("T3_err", err, 1);
      chk("T3_err_index", err_index, 40);
      chk("T3_done", done, 1);
      chk("T3_gen_en", gen_en, 0);

      // T4: reset after 60 accepts, then full reload
      fill_random();
      pulse_start();
      stream(0, 60, -1);
      rst = 1; cdf_valid = 1;
      tick();
      rst = 0; cdf_valid = 0;
      chk("T4_load_mem", load_mem, 0);
      chk("T4_ready", cdf_ready, 0);
      chk("T4_done", done, 0);
      want_first = 1;
      base = strobes;
      pulse_start();
      stream(2, DEPTH, -1);
      wait_done();
      tick();
      chk("T4_first_loc", first_loc, 0);
      chk("T4_strobes", strobes - base, 130);

      // T5: start during LOAD (entry 30) and during TAIL ignored
      fill_ramp();
      base = strobes;
      pulse_start();
      stream(0, DEPTH, 30);
      pulse_start();
      wait_done();
      tick();
      chk("T5_strobes", strobes - base, 130);
      chk("T5_done", done, 1);

      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
